carbonz480_pwr_seq: RTL and testbench

Power/reset sequencer and shutdown controller for the CarbonZ480 system top. It stages the peripheral and core reset releases. It owns the 32-bit signature register and the poweroff/timeout flags that the system bench watches. It also runs a heartbeat watchdog that forces a timed-out poweroff if the core stops making progress.

---
 rtl/carbonz480_pkg.sv | 23 ++
 rtl/carbonz480_pwr_wdt.sv | 36 +++
 rtl/carbonz480_pwr_seq.sv | 162 ++++++++++++++++
 tb/tb_carbonz480_pwr_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/carbonz480_pkg.sv
// Shared types and defaults for the CarbonZ480 power sequencer.
//   pwr_state_e          : sequencer state, encoding visible on state_o
//   CARBONZ480_SIG_RESET : reset value of the signature register
//   CARBONZ480_*_CYCLES  : default timing parameters
package carbonz480_pkg;

   typedef enum logic [2:0] {
      ST_HOLD   = 3'd0,
      ST_PERIPH = 3'd1,
      ST_RUN    = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_OFF    = 3'd4,
      ST_TRIP   = 3'd5
   } pwr_state_e;

   localparam logic [31:0] CARBONZ480_SIG_RESET = 32'h0;

   localparam int unsigned CARBONZ480_RST_HOLD_CYCLES   = 16;
   localparam int unsigned CARBONZ480_CORE_DELAY_CYCLES = 4;
   localparam int unsigned CARBONZ480_DRAIN_CYCLES      = 8;
   localparam int unsigned CARBONZ480_WDT_CYCLES        = 200000;

endpackage

// File: rtl/carbonz480_pwr_wdt.sv
// Heartbeat watchdog counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear counter to zero (has priority over frz)
//   frz        : hold counter value
//   trip       : counter has reached WDT_CYCLES-1 and is neither cleared nor frozen
module carbonz480_pwr_wdt
   import carbonz480_pkg::*;
#(
   parameter int unsigned WDT_CYCLES = CARBONZ480_WDT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic frz,
   output logic trip
);

   localparam int CW = $clog2(WDT_CYCLES) + 1;
   localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYCLES - 1);

   logic [CW-1:0] cnt_reg;

   // Saturates at the trip value so the counter never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (!frz && (cnt_reg != WDT_LAST)) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign trip = !clr && !frz && (cnt_reg == WDT_LAST);

endmodule

// File: rtl/carbonz480_pwr_seq.sv
// Power/reset sequencer and shutdown controller for the CarbonZ480 top.
//   clk, rst_n          : clock, asynchronous active-low reset
//   periph_rst_n        : peripheral reset (active low)
//   core_rst_n          : CPU core reset (active low)
//   sig_wr_valid/strb/data, sig_wr_ready : byte-lane signature write port
//   off_req, bus_idle   : shutdown request and bus quiescence
//   heartbeat           : core progress pulse feeding the watchdog
//   signature           : latched signature
//   poweroff, timeout   : sticky halt flags
//   state_o             : registered state encoding for debug
// Every output is a registered decode of the state register, so all
// outputs (state_o included) change together one cycle after the FSM moves.
module carbonz480_pwr_seq
   import carbonz480_pkg::*;
#(
   parameter int unsigned RST_HOLD_CYCLES   = CARBONZ480_RST_HOLD_CYCLES,
   parameter int unsigned CORE_DELAY_CYCLES = CARBONZ480_CORE_DELAY_CYCLES,
   parameter int unsigned DRAIN_CYCLES      = CARBONZ480_DRAIN_CYCLES,
   parameter int unsigned WDT_CYCLES        = CARBONZ480_WDT_CYCLES
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        periph_rst_n,
   output logic        core_rst_n,
   input  logic        sig_wr_valid,
   input  logic [3:0]  sig_wr_strb,
   input  logic [31:0] sig_wr_data,
   output logic        sig_wr_ready,
   input  logic        off_req,
   input  logic        bus_idle,
   input  logic        heartbeat,
   output logic [31:0] signature,
   output logic        poweroff,
   output logic        timeout,
   output logic [2:0]  state_o
);

   localparam int HOLD_W  = $clog2(RST_HOLD_CYCLES) + 1;
   localparam int CORE_W  = $clog2(CORE_DELAY_CYCLES) + 1;
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES) + 1;

   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CORE_W-1:0]  CORE_LAST  = CORE_W'(CORE_DELAY_CYCLES - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_DONE = DRAIN_W'(DRAIN_CYCLES);

   pwr_state_e         state_reg, state_next;
   logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
   logic [CORE_W-1:0]  core_cnt_reg, core_cnt_next;
   logic [DRAIN_W-1:0] idle_cnt_reg, idle_cnt_next;

   pwr_state_e         state_o_reg;
   logic               periph_rst_n_reg;
   logic               core_rst_n_reg;
   logic               sig_wr_ready_reg;
   logic               poweroff_reg;
   logic               timeout_reg;

   logic               wdt_clr;
   logic               wdt_frz;
   logic               wdt_trip;

   // Watchdog runs only in RUN, holds its count through DRAIN, and is
   // cleared everywhere else.
   assign wdt_frz = (state_reg == ST_DRAIN);
   assign wdt_clr = ((state_reg == ST_RUN) && heartbeat) ||
                    !((state_reg == ST_RUN) || (state_reg == ST_DRAIN));

   carbonz480_pwr_wdt #(
      .WDT_CYCLES (WDT_CYCLES)
   ) u_wdt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (wdt_clr),
      .frz   (wdt_frz),
      .trip  (wdt_trip)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_HOLD;
         hold_cnt_reg <= '0;
         core_cnt_reg <= '0;
         idle_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         hold_cnt_reg <= hold_cnt_next;
         core_cnt_reg <= core_cnt_next;
         idle_cnt_reg <= idle_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      core_cnt_next = core_cnt_reg;
      idle_cnt_next = idle_cnt_reg;
      case (state_reg)
         ST_HOLD: begin
            if (hold_cnt_reg == HOLD_LAST) state_next = ST_PERIPH;
            else                           hold_cnt_next = hold_cnt_reg + 1'b1;
         end
         ST_PERIPH: begin
            if (core_cnt_reg == CORE_LAST) state_next = ST_RUN;
            else                           core_cnt_next = core_cnt_reg + 1'b1;
         end
         ST_RUN: begin
            // A watchdog trip outranks a simultaneous shutdown request.
            if (wdt_trip)     state_next = ST_TRIP;
            else if (off_req) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            // off_req is no longer looked at: shutdown cannot be cancelled.
            if (idle_cnt_reg == DRAIN_DONE) state_next = ST_OFF;
            else if (bus_idle)              idle_cnt_next = idle_cnt_reg + 1'b1;
            else                            idle_cnt_next = '0;
         end
         default: ; // OFF and TRIP are terminal until rst_n
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_o_reg      <= ST_HOLD;
         periph_rst_n_reg <= 1'b0;
         core_rst_n_reg   <= 1'b0;
         sig_wr_ready_reg <= 1'b0;
         poweroff_reg     <= 1'b0;
         timeout_reg      <= 1'b0;
      end else begin
         state_o_reg      <= state_reg;
         periph_rst_n_reg <= state_reg inside {ST_PERIPH, ST_RUN, ST_DRAIN, ST_OFF};
         core_rst_n_reg   <= state_reg inside {ST_RUN, ST_DRAIN};
         sig_wr_ready_reg <= state_reg inside {ST_RUN, ST_DRAIN};
         poweroff_reg     <= state_reg inside {ST_OFF, ST_TRIP};
         timeout_reg      <= (state_reg == ST_TRIP);
      end
   end

   // Acceptance uses the registered ready, so a write presented while ready
   // is still high lands even on the edge where ready drops for OFF.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sig_lane
         logic [7:0] lane_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lane_reg <= CARBONZ480_SIG_RESET[8*gi +: 8];
            end else if (sig_wr_valid && sig_wr_ready_reg && sig_wr_strb[gi]) begin
               lane_reg <= sig_wr_data[8*gi +: 8];
            end
         end
         assign signature[8*gi +: 8] = lane_reg;
      end
   endgenerate

   assign state_o      = state_o_reg;
   assign periph_rst_n = periph_rst_n_reg;
   assign core_rst_n   = core_rst_n_reg;
   assign sig_wr_ready = sig_wr_ready_reg;
   assign poweroff     = poweroff_reg;
   assign timeout      = timeout_reg;

endmodule

// File: tb/tb_carbonz480_pwr_seq.sv
// Directed bench for carbonz480_pwr_seq (watchdog shortened to 100 cycles).
module tb_carbonz480_pwr_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        periph_rst_n;
   logic        core_rst_n;
   logic        sig_wr_valid = 1'b0;
   logic [3:0]  sig_wr_strb = 4'h0;
   logic [31:0] sig_wr_data = 32'h0;
   logic        sig_wr_ready;
   logic        off_req = 1'b0;
   logic        bus_idle = 1'b0;
   logic        heartbeat = 1'b0;
   logic [31:0] signature;
   logic        poweroff;
   logic        timeout;
   logic [2:0]  state_o;

   int n_checks = 0;
   int n_fail   = 0;
   int hb_cnt   = 0;
   bit hb_en    = 1'b1;

   always #5 clk = ~clk;

   carbonz480_pwr_seq #(
      .RST_HOLD_CYCLES   (16),
      .CORE_DELAY_CYCLES (4),
      .DRAIN_CYCLES      (8),
      .WDT_CYCLES        (100)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .periph_rst_n (periph_rst_n),
      .core_rst_n   (core_rst_n),
      .sig_wr_valid (sig_wr_valid),
      .sig_wr_strb  (sig_wr_strb),
      .sig_wr_data  (sig_wr_data),
      .sig_wr_ready (sig_wr_ready),
      .off_req      (off_req),
      .bus_idle     (bus_idle),
      .heartbeat    (heartbeat),
      .signature    (signature),
      .poweroff     (poweroff),
      .timeout      (timeout),
      .state_o      (state_o)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance to 1 ns after the next posedge; heartbeat pulses every 50 cycles when enabled.
   task automatic tick();
      @(posedge clk);
      #1;
      hb_cnt++;
      heartbeat = (hb_en && (hb_cnt % 50 == 0)) ? 1'b1 : 1'b0;
   endtask

   task automatic check_reset_vals(input string pfx);
      check_val({pfx, "_periph"},   periph_rst_n, 0);
      check_val({pfx, "_core"},     core_rst_n,   0);
      check_val({pfx, "_ready"},    sig_wr_ready, 0);
      check_val({pfx, "_sig"},      signature,    0);
      check_val({pfx, "_poweroff"}, poweroff,     0);
      check_val({pfx, "_timeout"},  timeout,      0);
      check_val({pfx, "_state"},    state_o,      0);
   endtask

   // rst_n has just been released mid-cycle: next posedge is number 1.
   task automatic seq_check();
      for (int p = 1; p <= 21; p++) begin
         tick();
         check_val($sformatf("periph_p%0d", p), periph_rst_n, (p >= 17) ? 1 : 0);
         check_val($sformatf("core_p%0d", p),   core_rst_n,   (p >= 21) ? 1 : 0);
         if (p == 20) check_val("state_p20", state_o, 1);
      end
      check_val("state_run", state_o, 2);
      check_val("ready_run", sig_wr_ready, 1);
   endtask

   task automatic power_up();
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst");
      for (int i = 0; i < 5; i++) tick();
      check_reset_vals("rst_hold");
      rst_n = 1'b1;
      seq_check();
   endtask

   task automatic do_write(input logic [31:0] d, input logic [3:0] s);
      sig_wr_valid = 1'b1;
      sig_wr_data  = d;
      sig_wr_strb  = s;
      tick();
      sig_wr_valid = 1'b0;
      $display("write data=%h strb=%h ready_now=%b signature=%h", d, s, sig_wr_ready, signature);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running, expected to finish");
      $fatal(1);
   end

   initial begin
      bit seen_off;

      // Scenario 1: power-up sequencing
      hb_en = 1'b1;
      power_up();

      // Scenario 2: signature writes
      do_write(32'h3038_345A, 4'hF);
      check_val("sig_full", signature, 32'h3038_345A);
      do_write(32'hFFFF_FFFF, 4'h2);
      check_val("sig_lane1", signature, 32'h3038_FF5A);

      // Scenario 3: drain then poweroff
      off_req = 1'b1;
      bus_idle = 1'b0;
      tick();
      bus_idle = 1'b1; tick();
      tick();
      bus_idle = 1'b0; tick();
      off_req = 1'b0;
      check_val("drain_state", state_o, 3);
      bus_idle = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         check_val($sformatf("drain_wait%0d", i), poweroff, 0);
      end
      check_val("drain_ready", sig_wr_ready, 1);
      // Write accepted on the same edge that shows OFF
      do_write(32'hA5A5_0000, 4'hC);
      check_val("off_poweroff", poweroff, 1);
      check_val("off_timeout", timeout, 0);
      check_val("off_core", core_rst_n, 0);
      check_val("off_periph", periph_rst_n, 1);
      check_val("off_state", state_o, 4);
      check_val("off_ready", sig_wr_ready, 0);
      check_val("off_lastwrite", signature, 32'hA5A5_FF5A);
      do_write(32'h0000_0000, 4'hF);
      check_val("off_sig_hold", signature, 32'hA5A5_FF5A);
      check_val("off_sticky", poweroff, 1);
      bus_idle = 1'b0;

      // Scenario 6: short mid-cycle reset while in OFF
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async");
      rst_n = 1'b1;
      seq_check();

      // Scenario 4b: heartbeat every 50 cycles keeps RUN alive
      seen_off = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (poweroff) seen_off = 1'b1;
      end
      check_val("hb_no_trip", seen_off, 0);
      check_val("hb_state", state_o, 2);
      check_val("hb_timeout", timeout, 0);

      // Scenario 4a: no heartbeat -> trip after 100 visible RUN cycles
      hb_en = 1'b0;
      heartbeat = 1'b0;
      power_up();
      for (int p = 22; p <= 120; p++) tick();
      check_val("wdt_p120_state", state_o, 2);
      check_val("wdt_p120_poweroff", poweroff, 0);
      tick();
      check_val("wdt_state", state_o, 5);
      check_val("wdt_poweroff", poweroff, 1);
      check_val("wdt_timeout", timeout, 1);
      check_val("wdt_core", core_rst_n, 0);
      check_val("wdt_periph", periph_rst_n, 0);
      check_val("trip_ready", sig_wr_ready, 0);
      do_write(32'hDEAD_BEEF, 4'hF);
      check_val("trip_sig_hold", signature, 32'h0);

      // Scenario 5: off_req in the very cycle the watchdog trips
      power_up();
      for (int p = 22; p <= 119; p++) tick();
      off_req = 1'b1;
      tick();
      check_val("race_p120_state", state_o, 2);
      tick();
      off_req = 1'b0;
      check_val("race_state", state_o, 5);
      check_val("race_timeout", timeout, 1);
      check_val("race_poweroff", poweroff, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
